boolexp_lut_sweep: RTL

Parametrised, registered Boolean-function block for the lab datapath. It replaces fixed hard-wired expressions with a loadable N-input truth table. Two modes run side by side:
- Evaluate: a registered output for a live input vector.
- Sweep: a sequencer walks every minterm, streams each result and counts the true minterms.

---
 rtl/boolexp_pkg.sv | 16 +
 rtl/lut_mux.sv | 15 +
 rtl/boolexp_lut_sweep.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/boolexp_pkg.sv
// Shared state encoding and sizing helpers for the loadable truth-table block.
package boolexp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } state_e;

   localparam logic [7:0] DEFAULT_TT3 = 8'hC7;

   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/lut_mux.sv
// Combinational truth-table lookup: returns bit idx of the table.
module lut_mux
   import boolexp_pkg::*;
#(
   parameter  int N_IN = 3,
   localparam int TT_W = tt_width(N_IN)
) (
   input  logic [TT_W-1:0] tt,
   input  logic [N_IN-1:0] idx,
   output logic            bit_o
);

   assign bit_o = tt[idx];

endmodule

// File: rtl/boolexp_lut_sweep.sv
// Loadable N-input Boolean function: registered live evaluation plus a
// minterm sweeper that streams every table entry and counts the true ones.
module boolexp_lut_sweep
   import boolexp_pkg::*;
#(
   parameter  int              N_IN    = 3,
   localparam int              TT_W    = tt_width(N_IN),
   parameter  logic [TT_W-1:0] INIT_TT = TT_W'(DEFAULT_TT3)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tt_load,
   input  logic [TT_W-1:0] tt_in,
   input  logic [N_IN-1:0] x,
   output logic            y,
   input  logic            start,
   output logic            busy,
   output logic            sweep_valid,
   output logic [N_IN-1:0] sweep_idx,
   output logic            sweep_y,
   output logic            done,
   output logic [N_IN:0]   ones_count
);

   state_e          state_q, state_d;
   logic [TT_W-1:0] table_q, table_d;
   logic [N_IN-1:0] cnt_q, cnt_d;
   logic [N_IN-1:0] sweep_idx_q, sweep_idx_d;
   logic [N_IN:0]   acc_q, acc_d;
   logic [N_IN:0]   ones_count_q, ones_count_d;
   logic            y_q, y_d;
   logic            busy_q, busy_d;
   logic            sweep_valid_q, sweep_valid_d;
   logic            sweep_y_q, sweep_y_d;
   logic            done_q, done_d;
   logic            eval_bit;
   logic            sweep_bit;

   lut_mux #(.N_IN(N_IN)) u_eval_mux (
      .tt   (table_q),
      .idx  (x),
      .bit_o(eval_bit)
   );

   lut_mux #(.N_IN(N_IN)) u_sweep_mux (
      .tt   (table_q),
      .idx  (cnt_q),
      .bit_o(sweep_bit)
   );

   always_comb begin
      // NOTE: every _d starts from a hold or default value, so no branch can leave a latch.
      state_d       = state_q;
      table_d       = table_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      ones_count_d  = ones_count_q;
      y_d           = eval_bit;
      busy_d        = busy_q;
      sweep_valid_d = 1'b0;
      sweep_idx_d   = sweep_idx_q;
      sweep_y_d     = sweep_y_q;
      done_d        = 1'b0;

      // Table is frozen while a sweep walks it.
      if (tt_load && (state_q == IDLE || state_q == DONE)) begin
         table_d = tt_in;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SWEEP;
               cnt_d   = '0;
               acc_d   = '0;
               busy_d  = 1'b1;
            end
         end
         SWEEP: begin
            sweep_valid_d = 1'b1;
            sweep_idx_d   = cnt_q;
            sweep_y_d     = sweep_bit;
            acc_d         = acc_q + (N_IN+1)'(sweep_bit);
            cnt_d         = cnt_q + N_IN'(1);
            if (cnt_q == N_IN'(TT_W - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_d       = 1'b1;
            ones_count_d = acc_q;
            busy_d       = 1'b0;
            state_d      = IDLE;
            if (start) begin
               state_d = SWEEP;
               cnt_d   = '0;
               acc_d   = '0;
               busy_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         // NOTE: the table is a plain register bank, not a RAM, so it can and must take a reset value.
         table_q       <= INIT_TT;
         cnt_q         <= '0;
         acc_q         <= '0;
         ones_count_q  <= '0;
         y_q           <= 1'b0;
         busy_q        <= 1'b0;
         sweep_valid_q <= 1'b0;
         sweep_idx_q   <= '0;
         sweep_y_q     <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         table_q       <= table_d;
         cnt_q         <= cnt_d;
         acc_q         <= acc_d;
         ones_count_q  <= ones_count_d;
         y_q           <= y_d;
         busy_q        <= busy_d;
         sweep_valid_q <= sweep_valid_d;
         sweep_idx_q   <= sweep_idx_d;
         sweep_y_q     <= sweep_y_d;
         done_q        <= done_d;
      end
   end

   assign y           = y_q;
   assign busy        = busy_q;
   assign sweep_valid = sweep_valid_q;
   assign sweep_idx   = sweep_idx_q;
   assign sweep_y     = sweep_y_q;
   assign done        = done_q;
   assign ones_count  = ones_count_q;

endmodule
